// File: rtl/fir_result_sink_pkg.sv
`default_nettype none
// ============================================================
// fir_result_sink_pkg -- shared state encoding, default widths, saturation helpers
// Rev 1.0
// ============================================================
package fir_result_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int c_def_in_w  = 65;
  localparam int c_def_out_w = 16;
  localparam int c_def_shift = 15;

  // Largest / smallest two's-complement value representable in w bits.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_result_sink_if.sv
`default_nettype none
// ============================================================
// fir_result_sink_if -- filter-result input and sample read-port bundle
// Rev 1.0
// ============================================================
interface fir_result_sink_if
  import fir_result_sink_pkg::*;
#(
  parameter int IN_W  = c_def_in_w,
  parameter int OUT_W = c_def_out_w
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;

  modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface
`default_nettype wire

// File: rtl/fir_result_sink_sync_fifo_fwft.sv
`default_nettype none
// ============================================================
// sync_fifo_fwft -- show-ahead FIFO; output holds last head while empty
// Rev 1.0
// ============================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int             c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_ptr_one = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] w_head;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_head    = r_mem[r_rd_ptr[c_aw-1:0]];
  assign o_data    = o_empty ? r_last : w_head;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (!o_empty) begin
        r_last <= w_head;
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fir_result_sink.sv
`default_nettype none
// ============================================================
// fir_result_sink -- round/saturate FIR results, buffer them, bounded capture FSM
// Rev 1.0
// ============================================================
module fir_result_sink
  import fir_result_sink_pkg::*;
#(
  parameter int IN_W  = c_def_in_w,
  parameter int OUT_W = c_def_out_w,
  parameter int SHIFT = c_def_shift,
  parameter int DEPTH = 16,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_cap_len,
  fir_result_sink_if.slave stream,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_sample_count,
  output logic [CNT_W-1:0] o_sat_count
);
  localparam logic signed [OUT_W-1:0] c_out_max = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0] c_out_min = OUT_W'(sat_min(OUT_W));
  localparam logic signed [IN_W:0]    c_half    = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [CNT_W-1:0]        c_cnt_one = 1;

  state_t r_state;
  state_t w_state_nx;

  logic [CNT_W-1:0] r_cap_len;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_sat_count;
  logic             r_drop;
  logic             r_stg_valid;
  logic [OUT_W-1:0] r_stg_data;

  logic signed [IN_W:0]         w_sum;
  logic signed [IN_W:0]         w_q;
  logic [IN_W-OUT_W+1:0]        w_hi;
  logic                         w_sat;
  logic [OUT_W-1:0]             w_scaled;
  logic                         w_go;
  logic                         w_zero;
  logic                         w_accept;
  logic                         w_last_accept;
  logic                         w_fifo_empty;
  logic                         w_fifo_full;
  logic                         w_drop_ev;

  // One extra bit of headroom so the rounding offset can never wrap.
  assign w_sum    = {stream.in_data[IN_W-1], stream.in_data} + c_half;
  assign w_q      = w_sum >>> SHIFT;
  assign w_hi     = w_q[IN_W:OUT_W-1];
  assign w_sat    = !((&w_hi) || !(|w_hi));
  assign w_scaled = !w_sat ? w_q[OUT_W-1:0] : (w_q[IN_W] ? c_out_min : c_out_max);

  assign w_go          = i_start && !i_clear && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_zero        = i_clear || w_go;
  assign w_accept      = stream.in_valid && !i_clear && (r_state == ST_CAPTURE);
  assign w_last_accept = w_accept && ((r_sample_count + c_cnt_one) == r_cap_len);
  assign w_drop_ev     = r_stg_valid && w_fifo_full && !(stream.out_ready && !w_fifo_empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (i_clear) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (i_start) w_state_nx = (i_cap_len == '0) ? ST_DRAIN : ST_CAPTURE;
        ST_CAPTURE:       if (w_last_accept) w_state_nx = ST_DRAIN;
        ST_DRAIN:         if (!r_stg_valid && w_fifo_empty) w_state_nx = ST_DONE;
        default:          w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
    end else begin
      r_stg_valid <= w_accept;
      if (w_accept) r_stg_data <= w_scaled;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_len      <= '0;
      r_sample_count <= '0;
      r_sat_count    <= '0;
      r_drop         <= 1'b0;
    end else begin
      if (w_go) r_cap_len <= i_cap_len;
      if (w_zero) begin
        r_sample_count <= '0;
        r_sat_count    <= '0;
        r_drop         <= 1'b0;
      end else begin
        if (w_accept) r_sample_count <= r_sample_count + c_cnt_one;
        if (w_accept && w_sat && !(&r_sat_count)) r_sat_count <= r_sat_count + c_cnt_one;
        if (w_drop_ev) r_drop <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_zero),
    .i_push  (r_stg_valid),
    .i_data  (r_stg_data),
    .i_pop   (stream.out_ready),
    .o_data  (stream.out_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign stream.out_valid = !w_fifo_empty;
  assign o_busy           = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
  assign o_done           = (r_state == ST_DONE);
  assign o_drop           = r_drop;
  assign o_sample_count   = r_sample_count;
  assign o_sat_count      = r_sat_count;
endmodule
`default_nettype wire

// File: doc/fir_result_sink.md
Name: fir_result_sink

Overview:
Capture-side endpoint for the FIR tree output stream, sitting at the opposite end from the sample feeder. It accepts the wide signed filter result (no backpressure on the filter side) and scales it with an arithmetic shift, round-half-up and saturation to a narrow sample. It buffers the results in a show-ahead FIFO and presents them on a valid/ready read port. A small FSM bounds the capture to a programmed number of samples and reports completion and statistics.

Parameters:
IN_W, 65, width of signed filter result
OUT_W, 16, width of signed output sample
SHIFT, 15, right-shift (fractional bits) applied before saturation; must be >=1
DEPTH, 16, FIFO entries (power of 2)
CNT_W, 11, width of length/statistics counters

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse, begins capture
clear  input  1  synchronous clear of FIFO/counters/flags/FSM to IDLE
cap_len  input  CNT_W  number of samples to capture, sampled on start
in_valid  input  1  filter result valid this cycle
in_data  input  IN_W  signed filter result
out_valid  output  1  FIFO head valid
out_data  output  OUT_W  signed FIFO head sample
out_ready  input  1  consumer pops head when out_valid&out_ready
busy  output  1  FSM in CAPTURE or DRAIN
done  output  1  FSM in DONE (level)
drop  output  1  sticky: a sample was lost to FIFO full
sample_count  output  CNT_W  samples accepted in current capture
sat_count  output  CNT_W  samples that saturated, saturating counter

Behaviour:
- Reset (rst low, async): FSM IDLE; FIFO empty; stage register invalid; all outputs 0 (out_data 0).
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE: in_valid ignored.
  - IDLE/DONE + start -> CAPTURE. This latches cap_len, zeroes sample_count, sat_count and drop, and empties the FIFO.
  - start while in CAPTURE/DRAIN: ignored.
  - CAPTURE: each in_valid is accepted and sample_count increments.
  - CAPTURE -> DRAIN: on the edge where sample_count reaches the latched cap_len.
  - cap_len=0: start goes directly to DRAIN.
  - DRAIN -> DONE: when the stage register is invalid and the FIFO is empty.
  - DONE holds until start or clear.
- clear has priority over start and in_valid and returns the FSM to IDLE. It applies the same zeroing as start.
- Scaling stage (1 register):
  - s = in_data + 2^(SHIFT-1), computed in IN_W+1 bits so it never wraps.
  - q = s >>> SHIFT.
  - q > 2^(OUT_W-1)-1 saturates to max; q < -2^(OUT_W-1) saturates to min. Either case increments sat_count, which holds at all-ones.
- Latency: in_valid sampled at edge N. The stage register is written at edge N. The FIFO is written at edge N+1. out_valid is high after edge N+1 if the FIFO was empty. There is no same-cycle bypass.
- FIFO:
  - Show-ahead: out_data equals the head whenever out_valid is high. out_data holds its last value when empty.
  - Pointers are CNT-free, log2(DEPTH)+1 bits, with natural wrap-around.
  - Full and stage valid with no pop that cycle: the sample is discarded and drop is set (sticky).
  - Full with pop and push in the same cycle: both occur and the count is unchanged.
  - Empty with push: out_valid rises the next cycle.
  - out_ready while empty: no effect.
- sample_count counts accepted inputs, including dropped ones.
- Reset mid-capture: immediate return to IDLE. FIFO contents are lost.

Decomposition:
- Shared package: FSM state encoding (IDLE/CAPTURE/DRAIN/DONE), OUT_W min/max saturation constants, default IN_W/OUT_W/SHIFT.
- One sub-module: sync_fifo_fwft (parameter WIDTH, DEPTH) for the show-ahead FIFO with full/empty flags. Scaling and FSM stay in the top level.

Test Plan:
- Rounding: SHIFT=15, cap_len=4, out_ready=1; inputs 3276800, 16384, -16384, -16385 -> out_data 100, 1, 0, -1; sat_count 0; done after last pop.
- Saturation: inputs 2^40, -2^40, 32767*2^15 -> 32767, -32768, 32767; sat_count 2.
- Full/drop: out_ready=0, cap_len=20, 20 consecutive in_valid -> 16 entries held (first 16 samples), drop=1, sample_count=20, FSM stays in DRAIN. Then out_ready=1 -> 16 pops in order, then done=1.
- Simultaneous push/pop at full: FIFO full, out_ready=1 with continuous input -> no drop, occupancy stays 16, output order preserved across pointer wrap for 40 samples.
- Control: start during CAPTURE ignored; clear mid-DRAIN -> IDLE with out_valid=0 and counters 0 next cycle; cap_len=0 -> DONE within 2 cycles; in_valid in IDLE produces no FIFO write.
- Async reset: drop rst low mid-capture between clock edges -> all outputs 0 immediately. After release, a start with cap_len=3 completes normally.
